// File: rtl/demux1_to_8_reg.sv
// Registered 1-to-8 demultiplexer with per-channel valid/ack handshake and accept counter.
// Optional macro DEMUX8_OVERWRITE_EN: never backpressure, flag overwrites of unconsumed data in ovf.
module demux1_to_8_reg #(
  parameter int WIDTH   = 32,
  parameter int COUNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     d_in,
  input  logic                 s2,
  input  logic                 s1,
  input  logic                 s0,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [8*WIDTH-1:0]   z,
  output logic [7:0]           z_valid,
  input  logic [7:0]           z_ack,
  output logic [7:0]           ovf,
  output logic [COUNT_W-1:0]   accept_cnt
);

  logic [2:0]              sel;
  logic                    accept;
  logic [7:0][WIDTH-1:0]   data_q;
  logic [7:0]              valid_q;
  logic [7:0]              valid_d;
  logic [COUNT_W-1:0]      cnt_q;

  assign sel = {s2, s1, s0};

`ifdef DEMUX8_OVERWRITE_EN
  assign in_ready = 1'b1;
`else
  // An ack in the same cycle frees the slot, so a full channel can still take a new word.
  assign in_ready = ~valid_q[sel] | z_ack[sel];
`endif

  assign accept = in_valid & in_ready;

  // The set from an accept dominates the clear from an ack on the same channel.
  always_comb begin
    valid_d = valid_q & ~z_ack;
    if (accept) begin
      valid_d[sel] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      if (accept) begin
        data_q[sel] <= d_in;
        cnt_q       <= cnt_q + COUNT_W'(1);
      end
    end
  end

`ifdef DEMUX8_OVERWRITE_EN
  logic [7:0] ovf_q;

  // Sticky: only a word landing on unconsumed, un-acked data counts as a loss.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= '0;
    end else if (accept && valid_q[sel] && !z_ack[sel]) begin
      ovf_q[sel] <= 1'b1;
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 8'h00;
`endif

  assign z          = data_q;
  assign z_valid    = valid_q;
  assign accept_cnt = cnt_q;

endmodule

// File: tb/tb_demux1_to_8_reg.sv
// Directed self-checking bench for demux1_to_8_reg; a second COUNT_W=4 instance covers counter wrap.
module tb_demux1_to_8_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] d_in;
  logic [2:0]  sel;
  logic        in_valid;
  logic        in_ready;
  logic [255:0] z;
  logic [7:0]  z_valid;
  logic [7:0]  z_ack;
  logic [7:0]  ovf;
  logic [15:0] accept_cnt;

  logic        in_valid2;
  logic        in_ready2;
  logic [255:0] z2;
  logic [7:0]  z_valid2;
  logic [7:0]  z_ack2;
  logic [7:0]  ovf2;
  logic [3:0]  accept_cnt2;

  int vectors = 0;
  int miscompares = 0;
  int expCnt = 0;

  always #5 clk = ~clk;

  demux1_to_8_reg #(.WIDTH(32), .COUNT_W(16)) dut (
    .clk(clk), .rst(rst), .d_in(d_in), .s2(sel[2]), .s1(sel[1]), .s0(sel[0]),
    .in_valid(in_valid), .in_ready(in_ready), .z(z), .z_valid(z_valid),
    .z_ack(z_ack), .ovf(ovf), .accept_cnt(accept_cnt)
  );

  demux1_to_8_reg #(.WIDTH(32), .COUNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .d_in(d_in), .s2(1'b0), .s1(1'b0), .s0(1'b0),
    .in_valid(in_valid2), .in_ready(in_ready2), .z(z2), .z_valid(z_valid2),
    .z_ack(z_ack2), .ovf(ovf2), .accept_cnt(accept_cnt2)
  );

  // Reference 8-to-1 mux: select k returns input (h..a)[k], i.e. slice k of z.
  function automatic logic [31:0] mux8(input logic [255:0] bus, input logic [2:0] k);
    return bus[k*32 +: 32];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; d_in = '0; sel = '0; in_valid = 1'b0; z_ack = '0;
    in_valid2 = 1'b0; z_ack2 = 8'hFF;
    #2;
    vectors++;
    if (z !== '0) begin miscompares++; $display("FAIL reset_z got %h want 0", z); end
    vectors++;
    if (z_valid !== 8'h00) begin miscompares++; $display("FAIL reset_zvalid got %h want 00", z_valid); end
    vectors++;
    if (ovf !== 8'h00) begin miscompares++; $display("FAIL reset_ovf got %h want 00", ovf); end
    vectors++;
    if (accept_cnt !== 16'd0) begin miscompares++; $display("FAIL reset_cnt got %0d want 0", accept_cnt); end
    #10;
    rst = 1'b0;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready got %b want 1", in_ready); end
  endtask

  task automatic test_wrap();
    in_valid2 = 1'b1;
    for (int i = 0; i < 15; i++) step();
    vectors++;
    if (accept_cnt2 !== 4'd15) begin miscompares++; $display("FAIL wrap_15 got %0d want 15", accept_cnt2); end
    for (int i = 0; i < 2; i++) step();
    in_valid2 = 1'b0;
    vectors++;
    if (accept_cnt2 !== 4'd1) begin miscompares++; $display("FAIL wrap_17 got %0d want 1", accept_cnt2); end
  endtask

  task automatic test_sweep();
    d_in = 32'hFFFFFFFF;
    in_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      sel = 3'(k);
      step();
    end
    in_valid = 1'b0;
    expCnt = 8;
    vectors++;
    if (z_valid !== 8'hFF) begin miscompares++; $display("FAIL sweep_zvalid got %h want FF", z_valid); end
    for (int k = 0; k < 8; k++) begin
      vectors++;
      if (mux8(z, 3'(k)) !== 32'hFFFFFFFF) begin
        miscompares++; $display("FAIL sweep_mux%0d got %h want FFFFFFFF", k, mux8(z, 3'(k)));
      end
    end
    vectors++;
    if (accept_cnt !== 16'(expCnt)) begin miscompares++; $display("FAIL sweep_cnt got %0d want %0d", accept_cnt, expCnt); end
  endtask

  task automatic test_backpressure();
    logic        expRdy;
    logic [31:0] expSlice;
    logic [7:0]  expOvf;
`ifdef DEMUX8_OVERWRITE_EN
    expRdy = 1'b1; expSlice = 32'h0; expOvf = 8'h08;
`else
    expRdy = 1'b0; expSlice = 32'hFFFFFFFF; expOvf = 8'h00;
`endif
    sel = 3'd3; d_in = 32'h0; in_valid = 1'b1; z_ack = 8'h00;
    #1;
    vectors++;
    if (in_ready !== expRdy) begin miscompares++; $display("FAIL bp_ready got %b want %b", in_ready, expRdy); end
    step();
    if (expRdy) expCnt++;
    vectors++;
    if (z[3*32 +: 32] !== expSlice) begin miscompares++; $display("FAIL bp_slice3 got %h want %h", z[3*32 +: 32], expSlice); end
    vectors++;
    if (accept_cnt !== 16'(expCnt)) begin miscompares++; $display("FAIL bp_cnt got %0d want %0d", accept_cnt, expCnt); end
    z_ack = 8'h08;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_ack_ready got %b want 1", in_ready); end
    step();
    expCnt++;
    in_valid = 1'b0; z_ack = 8'h00;
    vectors++;
    if (z_valid !== 8'hFF) begin miscompares++; $display("FAIL bp_ack_zvalid got %h want FF", z_valid); end
    vectors++;
    if (z[3*32 +: 32] !== 32'h0) begin miscompares++; $display("FAIL bp_ack_slice3 got %h want 0", z[3*32 +: 32]); end
    vectors++;
    if (accept_cnt !== 16'(expCnt)) begin miscompares++; $display("FAIL bp_ack_cnt got %0d want %0d", accept_cnt, expCnt); end
    vectors++;
    if (ovf !== expOvf) begin miscompares++; $display("FAIL bp_ovf got %h want %h", ovf, expOvf); end
  endtask

  task automatic test_ack();
    z_ack = 8'hFF;
    step();
    z_ack = 8'h00;
    vectors++;
    if (z_valid !== 8'h00) begin miscompares++; $display("FAIL ackall_zvalid got %h want 00", z_valid); end
    vectors++;
    if (z[7*32 +: 32] !== 32'hFFFFFFFF) begin miscompares++; $display("FAIL ackall_slice7 got %h want FFFFFFFF", z[7*32 +: 32]); end
    vectors++;
    if (z[3*32 +: 32] !== 32'h0) begin miscompares++; $display("FAIL ackall_slice3 got %h want 0", z[3*32 +: 32]); end
    z_ack = 8'h20;
    step();
    z_ack = 8'h00;
    vectors++;
    if (z_valid !== 8'h00) begin miscompares++; $display("FAIL ackempty_zvalid got %h want 00", z_valid); end
    vectors++;
    if (z[5*32 +: 32] !== 32'hFFFFFFFF) begin miscompares++; $display("FAIL ackempty_slice5 got %h want FFFFFFFF", z[5*32 +: 32]); end
    in_valid = 1'b1;
    sel = 3'd1; d_in = 32'h11111111; step();
    sel = 3'd2; d_in = 32'h22222222; step();
    sel = 3'd4; d_in = 32'h12345678; z_ack = 8'h06; step();
    in_valid = 1'b0; z_ack = 8'h00;
    expCnt += 3;
    vectors++;
    if (z_valid !== 8'h10) begin miscompares++; $display("FAIL multi_zvalid got %h want 10", z_valid); end
    vectors++;
    if (z[4*32 +: 32] !== 32'h12345678) begin miscompares++; $display("FAIL multi_slice4 got %h want 12345678", z[4*32 +: 32]); end
    vectors++;
    if (z[1*32 +: 32] !== 32'h11111111) begin miscompares++; $display("FAIL multi_slice1 got %h want 11111111", z[1*32 +: 32]); end
    vectors++;
    if (accept_cnt !== 16'(expCnt)) begin miscompares++; $display("FAIL multi_cnt got %0d want %0d", accept_cnt, expCnt); end
  endtask

  task automatic test_midrun_reset();
    sel = 3'd0; d_in = 32'hDEADBEEF; in_valid = 1'b1;
    #3;
    rst = 1'b1;
    #1;
    vectors++;
    if (z !== '0) begin miscompares++; $display("FAIL async_z got %h want 0", z); end
    vectors++;
    if (z_valid !== 8'h00) begin miscompares++; $display("FAIL async_zvalid got %h want 00", z_valid); end
    vectors++;
    if (accept_cnt !== 16'd0) begin miscompares++; $display("FAIL async_cnt got %0d want 0", accept_cnt); end
    vectors++;
    if (accept_cnt2 !== 4'd0) begin miscompares++; $display("FAIL async_cnt4 got %0d want 0", accept_cnt2); end
    step();
    in_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    expCnt = 0;
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL async_ready got %b want 1", in_ready); end
    vectors++;
    if (z_valid !== 8'h00) begin miscompares++; $display("FAIL async_hold_zvalid got %h want 00", z_valid); end
  endtask

  task automatic test_overwrite();
    logic        expRdy;
    logic [31:0] expSlice;
    logic [7:0]  expOvf;
`ifdef DEMUX8_OVERWRITE_EN
    expRdy = 1'b1; expSlice = 32'h5A5A5A5A; expOvf = 8'h40;
`else
    expRdy = 1'b0; expSlice = 32'hA5A5A5A5; expOvf = 8'h00;
`endif
    sel = 3'd6; d_in = 32'hA5A5A5A5; in_valid = 1'b1;
    step();
    expCnt++;
    d_in = 32'h5A5A5A5A;
    #1;
    vectors++;
    if (in_ready !== expRdy) begin miscompares++; $display("FAIL ow_ready got %b want %b", in_ready, expRdy); end
    step();
    if (expRdy) expCnt++;
    in_valid = 1'b0;
    vectors++;
    if (z[6*32 +: 32] !== expSlice) begin miscompares++; $display("FAIL ow_slice6 got %h want %h", z[6*32 +: 32], expSlice); end
    vectors++;
    if (z_valid !== 8'h40) begin miscompares++; $display("FAIL ow_zvalid got %h want 40", z_valid); end
    vectors++;
    if (accept_cnt !== 16'(expCnt)) begin miscompares++; $display("FAIL ow_cnt got %0d want %0d", accept_cnt, expCnt); end
    step(); step();
    vectors++;
    if (ovf !== expOvf) begin miscompares++; $display("FAIL ow_ovf_sticky got %h want %h", ovf, expOvf); end
    d_in = 32'hC3C3C3C3; z_ack = 8'h40; in_valid = 1'b1;
    step();
    in_valid = 1'b0; z_ack = 8'h00;
    vectors++;
    if (z[6*32 +: 32] !== 32'hC3C3C3C3) begin miscompares++; $display("FAIL ow_acked_slice6 got %h want C3C3C3C3", z[6*32 +: 32]); end
    vectors++;
    if (ovf !== expOvf) begin miscompares++; $display("FAIL ow_acked_ovf got %h want %h", ovf, expOvf); end
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if (ovf !== 8'h00) begin miscompares++; $display("FAIL ow_rst_ovf got %h want 00", ovf); end
    #2;
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_wrap();
    test_sweep();
    test_backpressure();
    test_ack();
    test_midrun_reset();
    test_overwrite();
    step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
